// File: rtl/cas_player.sv
// Cassette playback engine: streams CAS bytes from tape RAM and emits the
// 1200/2400 Hz FSK bit stream (LSB first) plus an 8-bit audio monitor sample.
module cas_player #(
  parameter int         ADDR_W = 16,
  parameter int         HALF0  = 23864,
  parameter int         HALF1  = 11932,
  parameter int         RD_LAT = 2,
  parameter logic [7:0] AMP    = 8'd32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              rewind,
  input  logic [ADDR_W:0]   tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              data,
  output logic [7:0]        audio,
  output logic [ADDR_W:0]   pos,
  output logic              eot,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_EOT} state_t;

  localparam int         HMAX  = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int         HW    = $clog2(HMAX + 1);
  localparam int         RW    = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [7:0] A_MID = 8'h80;
  localparam logic [7:0] A_HI  = A_MID + AMP;
  localparam logic [7:0] A_LO  = A_MID - AMP;

  state_t              r_state;
  logic [ADDR_W:0]     r_pos;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd;
  logic                r_data;
  logic [7:0]          r_audio;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit;
  logic                r_half;
  logic [HW-1:0]       r_hcnt;
  logic                r_rd_pend;
  logic [RW-1:0]       r_rd_cnt;
  logic [7:0]          r_nbuf;
  logic                r_nbuf_vld;
  logic                r_pf;

  logic                w_rd_done;
  logic [7:0]          w_fetched;
  logic                w_have;
  logic [ADDR_W:0]     w_pos_nx;
  logic                w_h_last;

  // The read tracker runs independently of en so a paused read still lands.
  assign w_rd_done = r_rd_pend && (r_rd_cnt == RW'(RD_LAT));
  assign w_fetched = w_rd_done ? mem_data : r_nbuf;
  assign w_have    = w_rd_done || r_nbuf_vld;
  assign w_pos_nx  = r_pos + (ADDR_W+1)'(1);
  assign w_h_last  = (r_hcnt == (r_shift[0] ? HW'(HALF1 - 1) : HW'(HALF0 - 1)));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_pos      <= '0;
      r_addr     <= '0;
      r_rd       <= 1'b0;
      r_data     <= 1'b0;
      r_audio    <= A_MID;
      r_shift    <= '0;
      r_bit      <= '0;
      r_half     <= 1'b0;
      r_hcnt     <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_cnt   <= '0;
      r_nbuf     <= '0;
      r_nbuf_vld <= 1'b0;
      r_pf       <= 1'b0;
    end else begin
      // NOTE: later non-blocking assignments in this block override earlier
      // defaults, so the tracker update below may be superseded by the FSM.
      r_rd <= 1'b0;
      if (r_rd_pend) begin
        if (w_rd_done) begin
          r_rd_pend  <= 1'b0;
          r_nbuf     <= mem_data;
          r_nbuf_vld <= 1'b1;
        end else begin
          r_rd_cnt <= r_rd_cnt + RW'(1);
        end
      end

      if (rewind) begin
        r_state    <= S_IDLE;
        r_pos      <= '0;
        r_data     <= 1'b0;
        r_audio    <= A_MID;
        r_rd_pend  <= 1'b0;
        r_nbuf_vld <= 1'b0;
        r_pf       <= 1'b0;
        r_bit      <= '0;
        r_half     <= 1'b0;
        r_hcnt     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (en) begin
              if (r_pos < tape_len) begin
                r_rd      <= 1'b1;
                r_addr    <= r_pos[ADDR_W-1:0];
                r_rd_pend <= 1'b1;
                r_rd_cnt  <= '0;
                r_state   <= S_FETCH;
              end else begin
                r_state <= S_EOT;
              end
            end
          end
          S_FETCH: begin
            if (en && w_have) begin
              r_shift    <= w_fetched;
              r_nbuf_vld <= 1'b0;
              r_bit      <= '0;
              r_half     <= 1'b0;
              r_hcnt     <= '0;
              r_data     <= 1'b1;
              r_audio    <= A_HI;
              r_state    <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (en) begin
              if (!w_h_last) begin
                r_hcnt <= r_hcnt + HW'(1);
              end else if (!r_half) begin
                r_half  <= 1'b1;
                r_hcnt  <= '0;
                r_data  <= 1'b0;
                r_audio <= A_LO;
              end else if (r_bit != 3'd7) begin
                r_bit   <= r_bit + 3'd1;
                r_shift <= {1'b0, r_shift[7:1]};
                r_half  <= 1'b0;
                r_hcnt  <= '0;
                r_data  <= 1'b1;
                r_audio <= A_HI;
                // Issue the prefetch so mem_rd lands on the first cycle of bit 7.
                if (r_bit == 3'd6 && w_pos_nx < tape_len) begin
                  r_rd      <= 1'b1;
                  r_addr    <= w_pos_nx[ADDR_W-1:0];
                  r_rd_pend <= 1'b1;
                  r_rd_cnt  <= '0;
                  r_pf      <= 1'b1;
                end
              end else begin
                r_pos <= w_pos_nx;
                if (r_pf) begin
                  r_pf       <= 1'b0;
                  r_shift    <= w_fetched;
                  r_nbuf_vld <= 1'b0;
                  r_bit      <= '0;
                  r_half     <= 1'b0;
                  r_hcnt     <= '0;
                  r_data     <= 1'b1;
                  r_audio    <= A_HI;
                end else begin
                  r_data  <= 1'b0;
                  r_audio <= A_MID;
                  r_state <= S_EOT;
                end
              end
            end
          end
          S_EOT:   r_state <= S_EOT;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_addr = r_addr;
  assign mem_rd   = r_rd;
  assign data     = r_data;
  assign audio    = r_audio;
  assign pos      = r_pos;
  assign eot      = (r_state == S_EOT);
  assign busy     = (r_state == S_FETCH) || (r_state == S_PLAY);

endmodule

// File: doc/cas_player.md
Name: cas_player

Overview:
- Parametrised cassette playback engine for the CoCo3 core: streams a CAS byte image from the tape RAM and produces the FSK bit stream the PIA cassette input expects. The encoding is 1200 Hz for a 0 bit and 2400 Hz for a 1 bit, sent LSB first.
- Successor to the fixed cassette block. It adds generic address width, frequency dividers and memory latency, gapless byte prefetch, pause/resume on motor relay, end-of-tape detection, and an 8-bit audio monitor output.

Parameters:
- ADDR_W, 16, tape RAM byte-address width.
- HALF0, 23864, clk cycles per half-period of a 0 bit (1200 Hz at 57.27 MHz).
- HALF1, 11932, clk cycles per half-period of a 1 bit (2400 Hz).
- RD_LAT, 2, cycles from the mem_rd strobe to valid mem_data. Constraint: RD_LAT < 2*HALF1.
- AMP, 8'd32, audio swing around 0x80.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  motor relay; 1 = play.
- rewind  in  1  level; while high, the tape is held at position 0.
- tape_len  in  ADDR_W+1  number of valid bytes in RAM.
- mem_addr  out  ADDR_W  byte address of the current read.
- mem_rd  out  1  one-cycle read strobe.
- mem_data  in  8  read data, valid RD_LAT cycles after mem_rd.
- data  out  1  FSK square wave to the PIA.
- audio  out  8  unsigned monitor sample.
- pos  out  ADDR_W+1  index of the byte currently playing.
- eot  out  1  end of tape.
- busy  out  1  high in FETCH or PLAY.

Behaviour:
- Reset (reset_n=0 at a clk edge): state IDLE; data=0, audio=0x80, mem_rd=0, mem_addr=0, pos=0, eot=0, busy=0, all counters 0.
- States: IDLE, FETCH, PLAY, EOT.
- IDLE:
  - if en=1 and pos<tape_len: assert mem_rd for one cycle with mem_addr=pos, then go to FETCH.
  - if en=1 and pos>=tape_len: go to EOT.
- FETCH: wait RD_LAT cycles, latch mem_data into the shift register, go to PLAY. The first data rising edge is at t0+RD_LAT+1, where t0 is the mem_rd cycle.
- Bit timing:
  - each bit is two half-periods of H = HALF1 if the bit is 1, HALF0 if 0.
  - data=1 for the first H cycles, data=0 for the next H cycles.
  - the next bit starts immediately; there is no inter-bit or inter-byte gap.
- audio = 0x80+AMP while data=1; 0x80-AMP while data=0 in PLAY; 0x80 otherwise.
- Prefetch: on the first cycle of bit 7, if pos+1<tape_len, strobe mem_rd with mem_addr=pos+1 and latch the result into a next-byte register after RD_LAT cycles.
- End of bit 7:
  - pos increments.
  - if the prefetch was issued, bit 0 of the next byte starts on the following cycle.
  - otherwise go to EOT.
- EOT: eot=1, data=0, audio=0x80, no reads. Only rewind or reset leaves EOT.
- Pause: en=0 in PLAY or FETCH freezes the half-period counter, bit index and data level. An outstanding read still completes and is latched. en=1 resumes on the exact cycle count where play stopped.
- Rewind:
  - overrides en and aborts any byte mid-play.
  - pos=0, eot=0, data=0, audio=0x80, state IDLE.
  - an in-flight read is discarded.
  - play restarts one cycle after rewind falls, if en=1.
- tape_len is sampled only at IDLE and at the prefetch decision. tape_len=0 with en=1 gives EOT the next cycle with no mem_rd.
- pos width ADDR_W+1 allows tape_len = 2^ADDR_W. mem_addr = pos[ADDR_W-1:0], so there is no address wrap within a valid tape.
- busy = state is FETCH or PLAY, including while paused.

Test Plan (HALF0=8, HALF1=4, RD_LAT=2, AMP=32):
- Single byte:
  - stimulus: RAM[0]=0xA5, tape_len=1, en raised at t0.
  - response: mem_rd at t0 with addr 0; data pattern 1,0,1,0,0,1,0,1 (LSB first); bit lengths 8/16/8/16/16/8/16/8 clocks (96 total); then eot=1, pos=1, data=0.
- Gapless two bytes:
  - stimulus: RAM={0xFF,0x00}, tape_len=2.
  - response: mem_rd addr 1 exactly on the first cycle of byte 0 bit 7; byte 1 bit 0 starts the cycle after byte 0 ends; total 64+128 clocks.
- Pause mid-bit:
  - stimulus: drop en 3 cycles into a 0 bit for 20 cycles, then raise it.
  - response: data holds 1 during the pause; 5 high cycles remain after resume; byte length increases by exactly 20.
- Rewind mid-byte:
  - stimulus: pulse rewind during bit 4 of byte 1.
  - response: pos=0, data=0, audio=0x80, eot=0 the next cycle; after release, mem_rd addr 0 is issued.
- Boundaries:
  - stimulus: tape_len=0 with en=1.
  - response: eot=1 and no mem_rd.
  - stimulus: reset_n low mid-play for 1 cycle.
  - response: all outputs return to reset values.
